// File: rtl/softmax_pkg.sv
// Shared constants for the softmax output path: default sizes, class-index width
// and the result-writer FSM state encoding.
package softmax_pkg;

    localparam int NUM_CLASS_DEF  = 10;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int CIDX_W         = 4;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    typedef logic [CIDX_W-1:0] class_idx_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a simultaneous push/pop path when full; the read
// port holds the last popped word while empty.
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/softmax_result_writer.sv
// Turns softmax write strobes into addressed result words, queues them for the
// host, and tracks the argmax / max score of each completed frame.
module softmax_result_writer
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_CLASS  = NUM_CLASS_DEF,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_data,
    input  logic [3:0]                      sel_data,
    input  logic [NUM_CLASS*DATA_WIDTH-1:0] data_in,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [3:0]                      argmax,
    output logic [DATA_WIDTH-1:0]           max_value,
    output logic                            done,
    output logic                            overflow_err,
    output logic                            sel_err
);

    localparam int WORD_W = DATA_WIDTH + ADDR_WIDTH;

    logic [0:0]                   state;
    logic [ADDR_WIDTH-1:0]        frame_base;
    logic signed [DATA_WIDTH-1:0] run_max;
    class_idx_t                   run_idx;

    logic                         in_range;
    logic                         accept;
    logic                         last_cls;
    class_idx_t                   k;
    logic signed [DATA_WIDTH-1:0] score;
    logic                         take_new;
    logic signed [DATA_WIDTH-1:0] next_max;
    class_idx_t                   next_idx;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [WORD_W-1:0]            rd_word;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;

    assign in_range = (sel_data != '0) && (sel_data <= CIDX_W'(NUM_CLASS));
    assign accept   = valid_data && in_range;
    assign k        = sel_data - CIDX_W'(1);
    assign last_cls = (k == CIDX_W'(NUM_CLASS - 1));
    assign wr_addr  = frame_base + ADDR_WIDTH'(k);

    always_comb begin
        score = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (k == CIDX_W'(i)) begin
                score = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The first element of a frame always seeds the tracker; later ones win only when strictly larger.
    assign take_new = (state == ST_IDLE) || (score > run_max);
    assign next_max = take_new ? score : run_max;
    assign next_idx = take_new ? k : run_idx;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = rd_word[WORD_W-1 -: DATA_WIDTH];
    assign out_addr  = rd_word[ADDR_WIDTH-1:0];

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .wr_data ({score, wr_addr}),
        .pop     (pop),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            frame_base   <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            argmax       <= '0;
            max_value    <= '0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (valid_data && !in_range) begin
                sel_err <= 1'b1;
            end
            if (accept && fifo_full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (accept) begin
                if (last_cls) begin
                    argmax     <= next_idx;
                    max_value  <= next_max;
                    done       <= 1'b1;
                    frame_base <= frame_base + ADDR_WIDTH'(NUM_CLASS);
                    state      <= ST_IDLE;
                end else begin
                    run_max <= next_max;
                    run_idx <= next_idx;
                    state   <= ST_COLLECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_softmax_result_writer.sv
// Directed bench for softmax_result_writer: a vector table for the nominal frame
// plus hand-written sequences for ties, backpressure, wrap, reset and bad selectors.
module tb_softmax_result_writer;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int AW = 8;
    localparam int FD = 4;

    typedef struct {
        logic        valid;
        logic [3:0]  sel;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_done;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             valid_data;
    logic [3:0]       sel_data;
    logic [NC*DW-1:0] data_in;
    logic             out_ready;

    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [AW-1:0]    out_addr;
    logic [3:0]       argmax;
    logic [DW-1:0]    max_value;
    logic             done;
    logic             overflow_err;
    logic             sel_err;

    // Second instance with a 4-bit address space to observe address wrap.
    logic             out_valid_w;
    logic [DW-1:0]    out_data_w;
    logic [3:0]       out_addr_w;
    logic [3:0]       argmax_w;
    logic [DW-1:0]    max_value_w;
    logic             done_w;
    logic             overflow_err_w;
    logic             sel_err_w;

    vec_t vecs[11];
    int   scores[NC];
    int   errors = 0;
    int   checks = 0;

    softmax_result_writer #(
        .DATA_WIDTH (DW), .NUM_CLASS (NC), .ADDR_WIDTH (AW), .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk), .rst_n (rst_n), .valid_data (valid_data), .sel_data (sel_data),
        .data_in (data_in), .out_ready (out_ready), .out_valid (out_valid),
        .out_data (out_data), .out_addr (out_addr), .argmax (argmax),
        .max_value (max_value), .done (done), .overflow_err (overflow_err),
        .sel_err (sel_err)
    );

    softmax_result_writer #(
        .DATA_WIDTH (DW), .NUM_CLASS (NC), .ADDR_WIDTH (4), .FIFO_DEPTH (FD)
    ) dut_wrap (
        .clk (clk), .rst_n (rst_n), .valid_data (valid_data), .sel_data (sel_data),
        .data_in (data_in), .out_ready (out_ready), .out_valid (out_valid_w),
        .out_data (out_data_w), .out_addr (out_addr_w), .argmax (argmax_w),
        .max_value (max_value_w), .done (done_w), .overflow_err (overflow_err_w),
        .sel_err (sel_err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] s, input logic r);
        valid_data = v;
        sel_data   = s;
        out_ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic loadScores();
        for (int i = 0; i < NC; i++) begin
            data_in[i*DW +: DW] = scores[i];
        end
    endtask

    task automatic normalScores();
        for (int i = 0; i < NC; i++) begin
            scores[i] = 10 * i;
        end
        scores[3] = 500;
        loadScores();
    endtask

    initial begin
        rst_n      = 1'b1;
        valid_data = 1'b0;
        sel_data   = '0;
        out_ready  = 1'b0;
        data_in    = '0;

        // Reset state
        doReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
        checkOutput("rst_argmax", 32'(argmax), 32'd0);
        checkOutput("rst_max_value", max_value, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_err), 32'd0);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);

        // Normal frame from the vector table
        normalScores();
        for (int i = 0; i < NC; i++) begin
            vecs[i] = '{valid: 1'b1, sel: 4'(i + 1), ready: 1'b1, exp_valid: 1'b1,
                        exp_addr: 8'(i), exp_data: scores[i], exp_done: (i == NC - 1)};
        end
        vecs[NC] = '{valid: 1'b0, sel: 4'd0, ready: 1'b1, exp_valid: 1'b0,
                     exp_addr: 8'd9, exp_data: 32'd90, exp_done: 1'b0};
        for (int i = 0; i < NC + 1; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].ready);
            checkOutput($sformatf("norm_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("norm_addr[%0d]", i), 32'(out_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("norm_data[%0d]", i), out_data, vecs[i].exp_data);
            checkOutput($sformatf("norm_done[%0d]", i), 32'(done), 32'(vecs[i].exp_done));
        end
        checkOutput("norm_argmax", 32'(argmax), 32'd3);
        checkOutput("norm_max", max_value, 32'd500);

        // Ties and negatives, then an all -100 frame back to back
        doReset();
        for (int i = 0; i < NC; i++) scores[i] = -5;
        scores[2] = 40;
        scores[7] = 40;
        loadScores();
        for (int i = 0; i < NC; i++) applyStimulus(1'b1, 4'(i + 1), 1'b1);
        checkOutput("tie_done", 32'(done), 32'd1);
        checkOutput("tie_argmax", 32'(argmax), 32'd2);
        checkOutput("tie_max", max_value, 32'd40);
        for (int i = 0; i < NC; i++) scores[i] = -100;
        loadScores();
        for (int i = 0; i < NC; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 1'b1);
            checkOutput($sformatf("neg_addr[%0d]", i), 32'(out_addr), 32'(10 + i));
        end
        checkOutput("neg_done", 32'(done), 32'd1);
        checkOutput("neg_argmax", 32'(argmax), 32'd0);
        checkOutput("neg_max", max_value, 32'hFFFF_FF9C);

        // Backpressure across a whole frame: only the first four words survive
        doReset();
        normalScores();
        for (int i = 0; i < NC; i++) applyStimulus(1'b1, 4'(i + 1), 1'b0);
        checkOutput("bp_done", 32'(done), 32'd1);
        checkOutput("bp_argmax", 32'(argmax), 32'd3);
        checkOutput("bp_max", max_value, 32'd500);
        checkOutput("bp_overflow", 32'(overflow_err), 32'd1);
        checkOutput("bp_head_addr0", 32'(out_addr), 32'd0);
        for (int j = 1; j < FD; j++) begin
            applyStimulus(1'b0, 4'd0, 1'b1);
            checkOutput($sformatf("bp_valid[%0d]", j), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_addr[%0d]", j), 32'(out_addr), 32'(j));
            checkOutput($sformatf("bp_data[%0d]", j), out_data, scores[j]);
        end
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("bp_drained", 32'(out_valid), 32'd0);
        checkOutput("bp_hold_addr", 32'(out_addr), 32'd3);

        // Push into a full FIFO while popping: nothing is dropped
        doReset();
        normalScores();
        for (int i = 0; i < FD; i++) applyStimulus(1'b1, 4'(i + 1), 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b1);
        checkOutput("fp_overflow", 32'(overflow_err), 32'd0);
        checkOutput("fp_head_addr", 32'(out_addr), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("fp_last_addr", 32'(out_addr), 32'd4);
        checkOutput("fp_last_data", out_data, 32'd40);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("fp_empty", 32'(out_valid), 32'd0);

        // Address wrap on the 4-bit instance over two frames
        doReset();
        for (int n = 0; n < 2 * NC; n++) begin
            applyStimulus(1'b1, 4'((n % NC) + 1), 1'b1);
            checkOutput($sformatf("wrap_addr[%0d]", n), 32'(out_addr_w), 32'(n % 16));
        end

        // Reset in the middle of a frame discards it
        doReset();
        normalScores();
        for (int i = 0; i < NC; i++) applyStimulus(1'b1, 4'(i + 1), 1'b1);
        checkOutput("pre_argmax", 32'(argmax), 32'd3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i + 1), 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_out_data", out_data, 32'd0);
        checkOutput("mid_out_addr", 32'(out_addr), 32'd0);
        checkOutput("mid_argmax", 32'(argmax), 32'd0);
        checkOutput("mid_max", max_value, 32'd0);
        checkOutput("mid_overflow", 32'(overflow_err), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("mid_no_done", 32'(done), 32'd0);

        // Bad selectors, then a lone last-class element completing a frame
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("sel0_err", 32'(sel_err), 32'd1);
        checkOutput("sel0_nopush", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 4'd12, 1'b0);
        checkOutput("sel12_err", 32'(sel_err), 32'd1);
        checkOutput("sel12_nopush", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 4'd10, 1'b1);
        checkOutput("single_done", 32'(done), 32'd1);
        checkOutput("single_argmax", 32'(argmax), 32'd9);
        checkOutput("single_max", max_value, 32'd90);
        checkOutput("single_addr", 32'(out_addr), 32'd9);
        checkOutput("single_sticky", 32'(sel_err), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("single_done_clr", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softmax_result_writer.md
# softmax_result_writer

Consumes the per-class write strobe produced by the softmax write-control stage (`valid_data`, `sel_data`) and turns each strobe into an addressed result word. Words go into a small output FIFO drained by the result-memory / host interface under a valid/ready handshake. Running argmax and max score are tracked over each frame of NUM_CLASS scores. The block sits directly downstream of the softmax write controller and is the last stage of the classifier output path.

## Interface
- DATA_WIDTH, 32, width of one softmax score (two's-complement signed)
- NUM_CLASS, 10, scores per frame; equals the write controller's OUTPUT_SIZE; range 2..15
- ADDR_WIDTH, 8, result-memory address width
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_data  in  1  write strobe from the softmax write controller
- sel_data  in  4  1-based class selector qualifying valid_data
- data_in  in  NUM_CLASS*DATA_WIDTH  packed scores; class i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_ready  in  1  downstream accepts the head word
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_WIDTH  head score
- out_addr  out  ADDR_WIDTH  head address
- argmax  out  4  0-based index of the largest score of the last completed frame
- max_value  out  DATA_WIDTH  score at argmax
- done  out  1  one-cycle pulse on frame completion
- overflow_err  out  1  sticky: word dropped because FIFO full
- sel_err  out  1  sticky: valid_data with sel_data outside 1..NUM_CLASS

## Operation
- Reset (rst_n low at an edge): FIFO empty, out_valid=0, out_data=0, out_addr=0, argmax=0, max_value=0, done=0, both error flags 0, frame_base=0, run_max/run_idx cleared, state IDLE. Reset mid-frame discards the partial frame; no done is issued.
- Accept: valid_data=1 and 1≤sel_data≤NUM_CLASS. k = sel_data−1. Word {score=data_in[k], addr=frame_base+k}, addr arithmetic mod 2^ADDR_WIDTH.
- valid_data=1 with sel_data out of range: no push, no tracker update, sel_err←1.
- FSM (2 states):
  - IDLE: on accept, running max←score_k, idx←k → COLLECT. If k==NUM_CLASS−1 as well (single-class frame corner), complete immediately.
  - COLLECT: on accept, update if score_k > running max (signed, strict; ties keep lower index). On accept with k==NUM_CLASS−1: argmax/max_value←final (including this element), done=1 next cycle, frame_base+=NUM_CLASS (wraps), → IDLE.
  - COLLECT with valid_data=0: stay; partial frame held, no timeout.
- argmax/max_value hold until the next frame completes.
- FIFO push on accept; pop when out_valid && out_ready.
- Push while full without simultaneous pop: word dropped, overflow_err←1; tracker and frame completion still update.
- Push while full with simultaneous pop: both occur, no drop.
- Error flags clear only by reset.

## Timing
- Accept at edge N → word visible on out_valid/out_data/out_addr after edge N (cycle N+1) if FIFO was empty.
- done high for exactly the cycle after the edge capturing the last class. argmax/max_value are valid in that same cycle.
- Pop is combinational on out_ready; the next head appears the following cycle.
- Sustained throughput: one accept per cycle. Back-to-back frames with no gap are legal: the first element of frame n+1 may arrive the cycle after frame n's last.
- Empty FIFO: out_ready ignored, out_data/out_addr hold last value.

## Structure
- Shared package `softmax_pkg`: NUM_CLASS default, DATA_WIDTH default, FSM state encoding (IDLE=0, COLLECT=1), class-index width constant.
- One sub-module: `sync_fifo` (parameterised width DATA_WIDTH+ADDR_WIDTH, depth FIFO_DEPTH, sync active-low reset, full/empty, same-cycle push/pop when full permitted).
- Top holds the FSM, tracker, frame_base counter and error flags.

## Test plan
- Normal frame: out_ready=1; scores class i = 10*i except class 3 = 500; sel_data 1..10 on consecutive cycles → addresses 0..9 in order, done one cycle after last, argmax=3, max_value=500.
- Ties and negatives: all scores −5 except classes 2 and 7 = 40 → argmax=2, max_value=40; second frame all −100 → argmax=0, max_value=−100, addresses 10..19.
- Backpressure/overflow: FIFO_DEPTH=4, out_ready=0 for a full frame → 4 words kept (addr 0..3), overflow_err=1, done and argmax still correct; then out_ready=1 drains exactly 4 words.
- Full + simultaneous pop: fill FIFO, then push with out_ready=1 in the same cycle → no drop, overflow_err stays 0.
- Address wrap: ADDR_WIDTH=4, NUM_CLASS=10, two frames → second frame addresses 10..15, 0..3.
- Reset and bad selector: assert rst_n=0 after 5 elements → all outputs 0, no done; then sel_data=0 and sel_data=12 with valid_data → sel_err=1, no FIFO push.
